ddr_cmd_responder: RTL and testbench
====================================

Name: ddr_cmd_responder

Overview:
- Device-side counterpart of the DDR SDRAM controller's command interface.
- Samples the controller's CKE/CS/RAS/CAS/WE/BA/A outputs and decodes each command.
- Tracks the JEDEC power-up/initialisation sequence and stores the mode and extended-mode register values.
- Enforces tRP/tMRD/tRFC/tRCD spacing and per-bank open/closed state.
- Used in simulation and on-board as a protocol checker, and as the source of "init complete" for the read-path work.

Parameters:
- T_RP, 3, minimum cycles from PRECHARGE to the next non-NOP command.
- T_MRD, 2, minimum cycles from LOAD MODE REGISTER to the next non-NOP command.
- T_RFC, 11, minimum cycles from AUTO REFRESH to the next non-NOP command.
- T_RCD, 2, minimum cycles from ACTIVE to READ/WRITE on any bank.
- MIN_REFRESH, 2, auto refreshes required during initialisation.

Ports:
- clk133  in  1  133 MHz clock; all inputs sampled on the rising edge (the controller launches on clk133_n).
- rst_n  in  1  asynchronous, active-low reset.
- sd_CKE  in  1  clock enable.
- sd_CS  in  1  chip select, active low.
- sd_RAS, sd_CAS, sd_WE  in  1 each  command bits.
- sd_BA  in  2  bank address.
- sd_A  in  13  address bus.
- mr_q  out  13  last value loaded into the mode register (BA=00).
- emr_q  out  13  last value loaded into the extended mode register (BA=01).
- init_done  out  1  initialisation sequence completed legally.
- bank_open  out  4  one bit per bank, set while a row is active.
- refresh_count  out  16  AUTO REFRESH commands accepted after init_done; wraps 0xFFFF to 0.
- err  out  1  sticky error flag.
- err_code  out  3  first error detected; sticky.

Behaviour:
- Reset (async, rst_n low): every output 0; state = S_POWERUP; timer = 0; rcd timer = 0.
- Command decode, {RAS,CAS,WE}:
  - 000 LMR, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 BST, 111 NOP.
  - CS=1 is treated as NOP.
  - While CKE=0 the inputs are ignored.
- Latency: a command sampled at edge k updates the outputs after edge k (registered, 1 cycle).
- Timer:
  - A legal command loads T-1 (PRE→T_RP, LMR→T_MRD, REF→T_RFC); the timer decrements each cycle, saturating at 0.
  - Any non-NOP sampled while timer≠0 is a timing error (code 2).
  - Example: PRE at cycle n permits the next command at n+T_RP.
- Init state machine (any command not listed for a state is a sequence error, code 1):
  - S_POWERUP: waits for CKE=1 → S_PRE1. NOPs are allowed in every state.
  - S_PRE1: PRE with A[10]=1 → S_EMR. PRE with A[10]=0 → code 3.
  - S_EMR: LMR with BA=01 → emr_q ← A, then → S_MR.
  - S_MR: LMR with BA=00 → mr_q ← A, then → S_PRE2.
  - S_PRE2: PRE with A[10]=1 → S_REF; refresh counter cleared.
  - S_REF: each REF increments the internal count. LMR with BA=00 and count ≥ MIN_REFRESH → mr_q ← A, then → S_READY. LMR with count < MIN_REFRESH → code 1.
  - S_READY: init_done=1. Sequence errors are no longer raised; bank rules apply instead.
- S_READY rules:
  - ACT on an open bank → code 4; otherwise set bank_open[BA] and load the rcd timer with T_RCD-1.
  - RD/WR on a closed bank, or while the rcd timer ≠ 0 → code 5.
  - PRE with A10=1 clears all bank_open bits; PRE with A10=0 clears bank_open[BA]. Either starts tRP.
  - REF with any bank open → code 6; otherwise refresh_count increments.
  - LMR with any bank open → code 6; otherwise updates mr_q or emr_q by BA.
- CKE falling while in S_READY with any bank open → code 7. CKE low before S_READY → return to S_POWERUP; mr_q, emr_q and err are retained.
- Error handling:
  - The first error sets err=1 and latches err_code; later errors never overwrite it.
  - After an error, the state machine keeps tracking (best effort).
- Simultaneous events: one command per cycle. A timing violation takes priority over a sequence or bank error in the same cycle; the command is still applied to state.
- Reset mid-sequence aborts everything immediately; outputs return to 0 asynchronously.

Decomposition:
- Package ddr_pkg holds:
  - command encodings (shared with the controller);
  - init-state enumeration;
  - err_code constants: 0 none, 1 seq, 2 timing, 3 pre-no-A10, 4 act-open, 5 rw-closed/tRCD, 6 bank-open-on-ref/lmr, 7 cke-drop;
  - default timing values.
- Sub-module ddr_cmd_timer: the loadable saturating down-counter with a violation output, instantiated twice (general and tRCD).

Test Plan:
- Legal init (NOPs, PRE A10=1, LMR BA=01 A=0, LMR BA=00 A=0x021, PRE, 2×REF spaced 11, LMR A=0x021) → init_done=1 after the last LMR edge, emr_q=0, mr_q=0x021, err=0.
- REF issued 10 cycles after the previous REF → err=1, err_code=2.
- Init with only 1 REF before the final LMR → err_code=1, init_done stays 0.
- After init: ACT bank 2, RD bank 2 one cycle later → err_code=5. Same with a 2-cycle gap → no error, bank_open=0100.
- ACT banks 0 and 3, then PRE A10=1 → bank_open=0000; REF 3 cycles later → refresh_count=1.
- rst_n pulsed low mid-S_REF → all outputs 0 asynchronously; a full legal init afterwards completes cleanly.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR command responder.
// Holds the command encodings used by the controller, the initialisation
// state enumeration, error codes and default timing values.
package ddr_pkg;

   // {RAS, CAS, WE}
   typedef enum logic [2:0] {
      CMD_LMR = 3'b000,
      CMD_REF = 3'b001,
      CMD_PRE = 3'b010,
      CMD_ACT = 3'b011,
      CMD_WR  = 3'b100,
      CMD_RD  = 3'b101,
      CMD_BST = 3'b110,
      CMD_NOP = 3'b111
   } cmd_e;

   typedef enum logic [2:0] {
      S_POWERUP = 3'd0,
      S_PRE1    = 3'd1,
      S_EMR     = 3'd2,
      S_MR      = 3'd3,
      S_PRE2    = 3'd4,
      S_REF     = 3'd5,
      S_READY   = 3'd6
   } init_state_e;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_SEQ      = 3'd1;
   localparam logic [2:0] ERR_TIMING   = 3'd2;
   localparam logic [2:0] ERR_PRE_A10  = 3'd3;
   localparam logic [2:0] ERR_ACT_OPEN = 3'd4;
   localparam logic [2:0] ERR_RW       = 3'd5;
   localparam logic [2:0] ERR_BANK_OPN = 3'd6;
   localparam logic [2:0] ERR_CKE      = 3'd7;

   localparam int DEF_T_RP        = 3;
   localparam int DEF_T_MRD       = 2;
   localparam int DEF_T_RFC       = 11;
   localparam int DEF_T_RCD       = 2;
   localparam int DEF_MIN_REFRESH = 2;

endpackage

// File: rtl/ddr_cmd_timer.sv
// Loadable down-counter that saturates at zero.
// Ports: clk133/rst_n clock and async active-low reset; load/load_val
// reload the count (load wins over decrement); check qualifies the
// violation output, viol = check while the count is non-zero.
module ddr_cmd_timer #(
   parameter int W = 4
) (
   input  logic         clk133,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         check,
   output logic         viol
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk133 or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign viol = check && (cnt_q != '0);

endmodule

// File: rtl/ddr_cmd_responder.sv
// Device-side DDR command responder / protocol checker.
// Decodes the controller's command bus each rising edge of clk133, tracks
// the power-up initialisation sequence, per-bank open state and command
// spacing, and flags the first protocol error.
// Ports: clk133, rst_n (async active-low); sd_* command bus inputs;
// mr_q/emr_q mode register copies; init_done; bank_open (one bit per bank);
// refresh_count (post-init REFs); err/err_code sticky first error.
//
// state     | meaning
// S_POWERUP | waiting for CKE high
// S_PRE1    | expecting PRECHARGE ALL
// S_EMR     | expecting LMR to extended mode register
// S_MR      | expecting LMR to mode register
// S_PRE2    | expecting second PRECHARGE ALL
// S_REF     | counting AUTO REFRESH, then final LMR
// S_READY   | initialised, bank rules enforced
module ddr_cmd_responder
   import ddr_pkg::*;
#(
   parameter int T_RP        = DEF_T_RP,
   parameter int T_MRD       = DEF_T_MRD,
   parameter int T_RFC       = DEF_T_RFC,
   parameter int T_RCD       = DEF_T_RCD,
   parameter int MIN_REFRESH = DEF_MIN_REFRESH
) (
   input  logic        clk133,
   input  logic        rst_n,
   input  logic        sd_CKE,
   input  logic        sd_CS,
   input  logic        sd_RAS,
   input  logic        sd_CAS,
   input  logic        sd_WE,
   input  logic [1:0]  sd_BA,
   input  logic [12:0] sd_A,
   output logic [12:0] mr_q,
   output logic [12:0] emr_q,
   output logic        init_done,
   output logic [3:0]  bank_open,
   output logic [15:0] refresh_count,
   output logic        err,
   output logic [2:0]  err_code
);

   init_state_e state_q, state_d;
   logic [12:0] mr_d, emr_d;
   logic [3:0]  bank_open_q, bank_open_d;
   logic [15:0] refresh_q, refresh_d;
   logic [3:0]  ref_init_q, ref_init_d;
   logic        err_q, err_d;
   logic [2:0]  err_code_q, err_code_d;
   logic        cke_q;

   cmd_e        cmd;
   logic        is_active, is_rw, any_open;
   logic [2:0]  code;
   logic        tmr_load, rcd_load;
   logic [3:0]  tmr_val;
   logic        tmr_viol, rcd_viol;

   ddr_cmd_timer #(.W(4)) u_gen_timer (
      .clk133   (clk133),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .check    (is_active),
      .viol     (tmr_viol)
   );

   ddr_cmd_timer #(.W(4)) u_rcd_timer (
      .clk133   (clk133),
      .rst_n    (rst_n),
      .load     (rcd_load),
      .load_val (4'(T_RCD - 1)),
      .check    (is_rw),
      .viol     (rcd_viol)
   );

   always_comb begin
      cmd = CMD_NOP;
      if (sd_CKE && !sd_CS)
         cmd = cmd_e'({sd_RAS, sd_CAS, sd_WE});
      is_active = (cmd != CMD_NOP);
      is_rw     = (cmd == CMD_RD) || (cmd == CMD_WR);
      any_open  = |bank_open_q;

      state_d     = state_q;
      mr_d        = mr_q;
      emr_d       = emr_q;
      bank_open_d = bank_open_q;
      refresh_d   = refresh_q;
      ref_init_d  = ref_init_q;
      err_d       = err_q;
      err_code_d  = err_code_q;
      code        = ERR_NONE;
      rcd_load    = 1'b0;

      case (state_q)
         S_POWERUP: begin
            if (sd_CKE) state_d = S_PRE1;
            if (is_active) code = ERR_SEQ;
         end
         S_PRE1, S_PRE2: begin
            if (cmd == CMD_PRE) begin
               if (sd_A[10]) begin
                  state_d    = (state_q == S_PRE1) ? S_EMR : S_REF;
                  ref_init_d = '0;
               end else begin
                  code = ERR_PRE_A10;
               end
            end else if (is_active) begin
               code = ERR_SEQ;
            end
         end
         S_EMR: begin
            if (cmd == CMD_LMR && sd_BA == 2'b01) begin
               emr_d   = sd_A;
               state_d = S_MR;
            end else if (is_active) begin
               code = ERR_SEQ;
            end
         end
         S_MR: begin
            if (cmd == CMD_LMR && sd_BA == 2'b00) begin
               mr_d    = sd_A;
               state_d = S_PRE2;
            end else if (is_active) begin
               code = ERR_SEQ;
            end
         end
         S_REF: begin
            if (cmd == CMD_REF) begin
               if (ref_init_q != 4'hF) ref_init_d = ref_init_q + 1'b1;
            end else if (cmd == CMD_LMR && sd_BA == 2'b00 &&
                         ref_init_q >= 4'(MIN_REFRESH)) begin
               mr_d    = sd_A;
               state_d = S_READY;
            end else if (is_active) begin
               code = ERR_SEQ;
            end
         end
         S_READY: begin
            case (cmd)
               CMD_ACT: begin
                  if (bank_open_q[sd_BA]) begin
                     code = ERR_ACT_OPEN;
                  end else begin
                     bank_open_d[sd_BA] = 1'b1;
                     rcd_load           = 1'b1;
                  end
               end
               CMD_RD, CMD_WR: begin
                  if (!bank_open_q[sd_BA] || rcd_viol) code = ERR_RW;
               end
               CMD_PRE: begin
                  if (sd_A[10]) bank_open_d = '0;
                  else          bank_open_d[sd_BA] = 1'b0;
               end
               CMD_REF: begin
                  if (any_open) code = ERR_BANK_OPN;
                  else          refresh_d = refresh_q + 1'b1;
               end
               CMD_LMR: begin
                  if (any_open)            code  = ERR_BANK_OPN;
                  else if (sd_BA == 2'b00) mr_d  = sd_A;
                  else if (sd_BA == 2'b01) emr_d = sd_A;
               end
               default: ;
            endcase
            // Entering power-down with a row still active loses the row.
            if (cke_q && !sd_CKE && any_open) code = ERR_CKE;
         end
         default: state_d = S_POWERUP;
      endcase

      // Losing CKE part-way through init restarts the sequence.
      if (!sd_CKE && state_q != S_READY) state_d = S_POWERUP;

      tmr_load = 1'b1;
      tmr_val  = '0;
      case (cmd)
         CMD_PRE: tmr_val  = 4'(T_RP - 1);
         CMD_LMR: tmr_val  = 4'(T_MRD - 1);
         CMD_REF: tmr_val  = 4'(T_RFC - 1);
         default: tmr_load = 1'b0;
      endcase

      // Timing wins the report; the command has already been applied above.
      if (tmr_viol) code = ERR_TIMING;

      if (!err_q && code != ERR_NONE) begin
         err_d      = 1'b1;
         err_code_d = code;
      end
   end

   always_ff @(posedge clk133 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_POWERUP;
         mr_q        <= '0;
         emr_q       <= '0;
         bank_open_q <= '0;
         refresh_q   <= '0;
         ref_init_q  <= '0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         cke_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mr_q        <= mr_d;
         emr_q       <= emr_d;
         bank_open_q <= bank_open_d;
         refresh_q   <= refresh_d;
         ref_init_q  <= ref_init_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         cke_q       <= sd_CKE;
      end
   end

   assign init_done     = (state_q == S_READY);
   assign bank_open     = bank_open_q;
   assign refresh_count = refresh_q;
   assign err           = err_q;
   assign err_code      = err_code_q;

endmodule

// File: tb/tb_ddr_cmd_responder.sv
module tb_ddr_cmd_responder;
   import ddr_pkg::*;

   logic        clk133 = 1'b0;
   logic        rst_n;
   logic        sd_CKE, sd_CS, sd_RAS, sd_CAS, sd_WE;
   logic [1:0]  sd_BA;
   logic [12:0] sd_A;
   logic [12:0] mr_q, emr_q;
   logic        init_done, err;
   logic [3:0]  bank_open;
   logic [15:0] refresh_count;
   logic [2:0]  err_code;

   int errors = 0;
   int checks = 0;

   always #4 clk133 = ~clk133;

   ddr_cmd_responder dut (
      .clk133(clk133), .rst_n(rst_n), .sd_CKE(sd_CKE), .sd_CS(sd_CS),
      .sd_RAS(sd_RAS), .sd_CAS(sd_CAS), .sd_WE(sd_WE), .sd_BA(sd_BA),
      .sd_A(sd_A), .mr_q(mr_q), .emr_q(emr_q), .init_done(init_done),
      .bank_open(bank_open), .refresh_count(refresh_count), .err(err),
      .err_code(err_code)
   );

   task automatic drive_nop();
      sd_CS = 1'b0;
      {sd_RAS, sd_CAS, sd_WE} = 3'b111;
      sd_BA = 2'b00;
      sd_A  = 13'h0;
   endtask

   task automatic nops(input int n);
      repeat (n) @(posedge clk133);
      #1;
   endtask

   // Drives one command for exactly one rising edge, then returns to NOP.
   task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a);
      sd_CS = 1'b0;
      {sd_RAS, sd_CAS, sd_WE} = c;
      sd_BA = ba;
      sd_A  = a;
      @(posedge clk133);
      #1;
      drive_nop();
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      sd_CKE = 1'b0;
      drive_nop();
      #2;
      @(posedge clk133);
      #1;
      rst_n = 1'b1;
      nops(1);
   endtask

   // Power-up through the first REF (leaves the FSM in S_REF).
   task automatic init_head();
      sd_CKE = 1'b1;
      nops(1);
      issue(CMD_PRE, 2'b00, 13'h400);
      nops(2);
      issue(CMD_LMR, 2'b01, 13'h000);
      nops(1);
      issue(CMD_LMR, 2'b00, 13'h021);
      nops(1);
      issue(CMD_PRE, 2'b00, 13'h400);
      nops(2);
      issue(CMD_REF, 2'b00, 13'h000);
   endtask

   task automatic init_seq(input int nref, input int gap);
      init_head();
      for (int i = 1; i < nref; i++) begin
         nops(gap - 1);
         issue(CMD_REF, 2'b00, 13'h000);
      end
      nops(10);
      issue(CMD_LMR, 2'b00, 13'h021);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sd_CKE = 1'b0;
      drive_nop();
      #3;
      checks++; if (mr_q !== 13'h0) begin errors++; $display("FAIL reset_mr: got %h want 0", mr_q); end
      checks++; if (emr_q !== 13'h0) begin errors++; $display("FAIL reset_emr: got %h want 0", emr_q); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
      checks++; if (bank_open !== 4'h0) begin errors++; $display("FAIL reset_bank_open: got %b want 0000", bank_open); end
      checks++; if (refresh_count !== 16'h0) begin errors++; $display("FAIL reset_refcnt: got %h want 0", refresh_count); end
      checks++; if ({err, err_code} !== 4'h0) begin errors++; $display("FAIL reset_err: got %b/%0d want 0/0", err, err_code); end
      @(posedge clk133);
      #1;
      rst_n = 1'b1;
      nops(1);
   endtask

   task automatic test_legal_init();
      do_reset();
      init_head();
      nops(10);
      issue(CMD_REF, 2'b00, 13'h000);
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early: got %b want 0", init_done); end
      nops(10);
      issue(CMD_LMR, 2'b00, 13'h021);
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL legal_init_done: got %b want 1", init_done); end
      checks++; if (emr_q !== 13'h000) begin errors++; $display("FAIL legal_emr: got %h want 000", emr_q); end
      checks++; if (mr_q !== 13'h021) begin errors++; $display("FAIL legal_mr: got %h want 021", mr_q); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL legal_err: got %b code %0d want 0", err, err_code); end
      checks++; if (refresh_count !== 16'h0) begin errors++; $display("FAIL legal_refcnt: got %0d want 0", refresh_count); end
   endtask

   task automatic test_ref_timing();
      do_reset();
      init_seq(2, 10);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ref_timing_err: got %b want 1", err); end
      checks++; if (err_code !== ERR_TIMING) begin errors++; $display("FAIL ref_timing_code: got %0d want 2", err_code); end
      // The early REF is still counted, so the final LMR completes init.
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL ref_timing_done: got %b want 1", init_done); end
   endtask

   task automatic test_short_init();
      do_reset();
      init_seq(1, 11);
      checks++; if (err_code !== ERR_SEQ) begin errors++; $display("FAIL short_init_code: got %0d want 1", err_code); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL short_init_done: got %b want 0", init_done); end
   endtask

   task automatic test_rcd();
      do_reset();
      init_seq(2, 11);
      nops(1);
      issue(CMD_ACT, 2'd2, 13'h055);
      issue(CMD_RD, 2'd2, 13'h000);
      checks++; if (err_code !== ERR_RW) begin errors++; $display("FAIL rcd_short_code: got %0d want 5", err_code); end
      checks++; if (bank_open !== 4'b0100) begin errors++; $display("FAIL rcd_short_bank: got %b want 0100", bank_open); end
      do_reset();
      init_seq(2, 11);
      nops(1);
      issue(CMD_ACT, 2'd2, 13'h055);
      nops(1);
      issue(CMD_RD, 2'd2, 13'h000);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rcd_ok_err: got %b code %0d want 0", err, err_code); end
      checks++; if (bank_open !== 4'b0100) begin errors++; $display("FAIL rcd_ok_bank: got %b want 0100", bank_open); end
   endtask

   // Continues from the clean state left by test_rcd (bank 2 open).
   task automatic test_pre_all_ref();
      issue(CMD_ACT, 2'd0, 13'h001);
      issue(CMD_ACT, 2'd3, 13'h002);
      checks++; if (bank_open !== 4'b1101) begin errors++; $display("FAIL act_banks: got %b want 1101", bank_open); end
      issue(CMD_PRE, 2'd0, 13'h400);
      checks++; if (bank_open !== 4'b0000) begin errors++; $display("FAIL pre_all: got %b want 0000", bank_open); end
      nops(2);
      issue(CMD_REF, 2'd0, 13'h000);
      checks++; if (refresh_count !== 16'd1) begin errors++; $display("FAIL refcnt_1: got %0d want 1", refresh_count); end
      nops(10);
      issue(CMD_REF, 2'd0, 13'h000);
      checks++; if (refresh_count !== 16'd2) begin errors++; $display("FAIL refcnt_2: got %0d want 2", refresh_count); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL pre_ref_err: got %b code %0d want 0", err, err_code); end
   endtask

   task automatic test_bank_errors();
      do_reset();
      init_seq(2, 11);
      nops(1);
      issue(CMD_ACT, 2'd1, 13'h010);
      issue(CMD_ACT, 2'd1, 13'h011);
      checks++; if (err_code !== ERR_ACT_OPEN) begin errors++; $display("FAIL act_open_code: got %0d want 4", err_code); end
      do_reset();
      init_seq(2, 11);
      nops(1);
      issue(CMD_ACT, 2'd0, 13'h010);
      nops(1);
      issue(CMD_REF, 2'd0, 13'h000);
      checks++; if (err_code !== ERR_BANK_OPN) begin errors++; $display("FAIL ref_open_code: got %0d want 6", err_code); end
      do_reset();
      init_seq(2, 11);
      nops(1);
      issue(CMD_ACT, 2'd0, 13'h010);
      sd_CKE = 1'b0;
      nops(1);
      checks++; if (err_code !== ERR_CKE) begin errors++; $display("FAIL cke_drop_code: got %0d want 7", err_code); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      init_head();
      checks++; if (mr_q !== 13'h021) begin errors++; $display("FAIL mid_pre_mr: got %h want 021", mr_q); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (mr_q !== 13'h0) begin errors++; $display("FAIL mid_async_mr: got %h want 0", mr_q); end
      checks++; if ({init_done, err, err_code, bank_open} !== 9'h0) begin errors++; $display("FAIL mid_async_misc: got %h want 0", {init_done, err, err_code, bank_open}); end
      sd_CKE = 1'b0;
      @(posedge clk133);
      #1;
      rst_n = 1'b1;
      nops(1);
      init_seq(2, 11);
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL mid_reinit_done: got %b want 1", init_done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_reinit_err: got %b code %0d want 0", err, err_code); end
      checks++; if (mr_q !== 13'h021) begin errors++; $display("FAIL mid_reinit_mr: got %h want 021", mr_q); end
   endtask

   initial begin
      test_reset();
      test_legal_init();
      test_ref_timing();
      test_short_init();
      test_rcd();
      test_pre_all_ref();
      test_bank_errors();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
